// File: rtl/mem_stage_pkg.sv
// Shared types and funct3 codes for the MEM pipeline stage.
// Imported by the stage top and its lane-alignment helper.
package mem_stage_pkg;

    typedef enum logic {IDLE, REQ} mem_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [3:0] BE_ALL = 4'b1111;

endpackage

// File: rtl/load_store_align.sv
// Byte-lane steering for RV32I loads and stores.
// Purely combinational: byte enables, store replication, load extension.
module load_store_align
    import mem_stage_pkg::*;
(
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_funct3,
    input  logic        i_is_store,
    input  logic [31:0] i_sdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_ldata,
    output logic        o_misalign
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        unique case (i_addr_lo)
            2'd0: w_byte = i_rdata[7:0];
            2'd1: w_byte = i_rdata[15:8];
            2'd2: w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    always_comb begin
        o_be       = BE_ALL;
        o_wdata    = i_sdata;
        o_ldata    = i_rdata;
        o_misalign = 1'b0;
        case (i_funct3)
            F3_B: begin
                o_ldata = {{24{w_byte[7]}}, w_byte};
                o_wdata = {4{i_sdata[7:0]}};
                if (i_is_store)
                    o_be = 4'b0001 << i_addr_lo;
            end
            F3_H: begin
                o_misalign = i_addr_lo[0];
                o_ldata    = {{16{w_half[15]}}, w_half};
                o_wdata    = {2{i_sdata[15:0]}};
                if (i_is_store)
                    o_be = i_addr_lo[1] ? 4'b1100 : 4'b0011;
            end
            F3_W: begin
                o_misalign = |i_addr_lo;
            end
            F3_BU: begin
                o_misalign = i_is_store;
                o_ldata    = {24'h0, w_byte};
            end
            F3_HU: begin
                o_misalign = i_is_store | i_addr_lo[0];
                o_ldata    = {16'h0, w_half};
            end
            default: begin
                o_misalign = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: req/ack data bus master with stall and bubbles.
// Holds the FSM, ack timeout counter and per-access capture registers.
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] store_data_in,
    input  logic [2:0]  funct3_in,
    input  logic [4:0]  rd_in,
    input  logic        reg_w_ctrl,
    input  logic        mem_r_ctrl,
    input  logic        mem_w_ctrl,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic [31:0] mem_r_data_out,
    output logic [31:0] alu_result_out,
    output logic [4:0]  rd_out,
    output logic        reg_write_out,
    output logic        mem_to_reg_out,
    output logic        misalign_fault,
    output logic        bus_fault
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    mem_state_t  r_state;
    mem_state_t  w_next;
    logic [7:0]  r_cnt;
    logic [31:0] r_addr;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic [2:0]  r_funct3;
    logic [4:0]  r_rd;
    logic        r_regw;
    logic        r_we;

    logic        w_in_req;
    logic        w_access;
    logic        w_accept;
    logic        w_timeout;
    logic [1:0]  w_addr_lo;
    logic [2:0]  w_funct3;
    logic        w_is_store;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_ldata;
    logic        w_misalign;

    assign w_in_req = (r_state == REQ);
    assign w_access = valid_in & (mem_r_ctrl | mem_w_ctrl);
    assign w_accept = !w_in_req & w_access & !w_misalign;
    assign w_timeout = w_in_req & !dmem_ack & (r_cnt == CNT_LAST);

    // Decode the incoming op while idle, the captured one while on the bus.
    assign w_addr_lo  = w_in_req ? r_addr[1:0] : alu_result_in[1:0];
    assign w_funct3   = w_in_req ? r_funct3 : funct3_in;
    assign w_is_store = w_in_req ? r_we : mem_w_ctrl;

    load_store_align u_align (
        .i_addr_lo  (w_addr_lo),
        .i_funct3   (w_funct3),
        .i_is_store (w_is_store),
        .i_sdata    (store_data_in),
        .i_rdata    (dmem_rdata),
        .o_be       (w_be),
        .o_wdata    (w_wdata),
        .o_ldata    (w_ldata),
        .o_misalign (w_misalign)
    );

    assign dmem_req   = w_in_req;
    assign dmem_we    = w_in_req & r_we;
    assign dmem_addr  = {r_addr[31:2], 2'b00};
    assign dmem_wdata = r_wdata;
    assign dmem_be    = r_be;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt    <= 8'h0;
            r_addr   <= 32'h0;
            r_be     <= 4'h0;
            r_wdata  <= 32'h0;
            r_funct3 <= 3'h0;
            r_rd     <= 5'h0;
            r_regw   <= 1'b0;
            r_we     <= 1'b0;
        end else if (w_accept) begin
            r_cnt    <= 8'h0;
            r_addr   <= alu_result_in;
            r_be     <= w_be;
            r_wdata  <= w_wdata;
            r_funct3 <= funct3_in;
            r_rd     <= rd_in;
            r_regw   <= reg_w_ctrl;
            r_we     <= mem_w_ctrl;
        end else if (w_in_req && !dmem_ack) begin
            r_cnt <= r_cnt + 8'h1;
        end
    end

    always_comb begin
        w_next         = r_state;
        mem_stall      = 1'b0;
        reg_write_out  = 1'b0;
        mem_to_reg_out = 1'b0;
        mem_r_data_out = 32'h0;
        alu_result_out = alu_result_in;
        rd_out         = rd_in;
        misalign_fault = 1'b0;
        bus_fault      = 1'b0;
        unique case (r_state)
            IDLE: begin
                reg_write_out  = valid_in & reg_w_ctrl & !w_access;
                misalign_fault = w_access & w_misalign;
                mem_stall      = w_accept;
                if (w_accept)
                    w_next = REQ;
            end
            REQ: begin
                alu_result_out = r_addr;
                rd_out         = r_rd;
                mem_r_data_out = w_ldata;
                if (dmem_ack) begin
                    w_next         = IDLE;
                    reg_write_out  = !r_we & r_regw;
                    mem_to_reg_out = !r_we;
                end else if (w_timeout) begin
                    w_next    = IDLE;
                    bus_fault = 1'b1;
                end else begin
                    mem_stall = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed-vector bench for mem_access_stage.
// Hand-computed expectations for pass-through, loads, stores, faults, reset.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in;
    logic [31:0] alu_result_in;
    logic [31:0] store_data_in;
    logic [2:0]  funct3_in;
    logic [4:0]  rd_in;
    logic        reg_w_ctrl;
    logic        mem_r_ctrl;
    logic        mem_w_ctrl;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        mem_stall;
    logic [31:0] mem_r_data_out;
    logic [31:0] alu_result_out;
    logic [4:0]  rd_out;
    logic        reg_write_out;
    logic        mem_to_reg_out;
    logic        misalign_fault;
    logic        bus_fault;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_access_stage #(.TIMEOUT_CYCLES(255)) dut (
        .clk            (clk),
        .reset          (reset),
        .valid_in       (valid_in),
        .alu_result_in  (alu_result_in),
        .store_data_in  (store_data_in),
        .funct3_in      (funct3_in),
        .rd_in          (rd_in),
        .reg_w_ctrl     (reg_w_ctrl),
        .mem_r_ctrl     (mem_r_ctrl),
        .mem_w_ctrl     (mem_w_ctrl),
        .dmem_req       (dmem_req),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_wdata     (dmem_wdata),
        .dmem_be        (dmem_be),
        .dmem_ack       (dmem_ack),
        .dmem_rdata     (dmem_rdata),
        .mem_stall      (mem_stall),
        .mem_r_data_out (mem_r_data_out),
        .alu_result_out (alu_result_out),
        .rd_out         (rd_out),
        .reg_write_out  (reg_write_out),
        .mem_to_reg_out (mem_to_reg_out),
        .misalign_fault (misalign_fault),
        .bus_fault      (bus_fault)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] a,
                         input logic [31:0] sd, input logic [2:0] f3,
                         input logic [4:0] rd, input logic rw,
                         input logic mr, input logic mw);
        valid_in      = v;
        alu_result_in = a;
        store_data_in = sd;
        funct3_in     = f3;
        rd_in         = rd;
        reg_w_ctrl    = rw;
        mem_r_ctrl    = mr;
        mem_w_ctrl    = mw;
    endtask

    task automatic idle_inputs();
        drive(1'b0, 32'h0, 32'h0, 3'b000, 5'd0, 1'b0, 1'b0, 1'b0);
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
    endtask

    initial begin
        int  n_req;
        bit  seen;
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req", 32'(dmem_req), 32'h0);
        chk("rst_stall", 32'(mem_stall), 32'h0);
        chk("rst_rdaddr", dmem_addr, 32'h0);
        reset = 1'b0;

        // 1: ALU pass-through
        @(negedge clk);
        drive(1'b1, 32'h1234, 32'h0, 3'b000, 5'd5, 1'b1, 1'b0, 1'b0);
        #1;
        chk("alu_rd", 32'(rd_out), 32'd5);
        chk("alu_rw", 32'(reg_write_out), 32'h1);
        chk("alu_stall", 32'(mem_stall), 32'h0);
        chk("alu_res", alu_result_out, 32'h1234);
        chk("alu_m2r", 32'(mem_to_reg_out), 32'h0);

        // 2: LB 0x103, ack in first REQ cycle
        @(negedge clk);
        drive(1'b1, 32'h103, 32'h0, 3'b000, 5'd7, 1'b1, 1'b1, 1'b0);
        #1;
        chk("lb_stall0", 32'(mem_stall), 32'h1);
        chk("lb_rw0", 32'(reg_write_out), 32'h0);
        chk("lb_req0", 32'(dmem_req), 32'h0);
        @(negedge clk);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h80FF_FFFF;
        #1;
        chk("lb_req1", 32'(dmem_req), 32'h1);
        chk("lb_addr", dmem_addr, 32'h100);
        chk("lb_we", 32'(dmem_we), 32'h0);
        chk("lb_be", 32'(dmem_be), 32'hF);
        chk("lb_stall1", 32'(mem_stall), 32'h0);
        chk("lb_data", mem_r_data_out, 32'hFFFF_FF80);
        chk("lb_rw1", 32'(reg_write_out), 32'h1);
        chk("lb_m2r", 32'(mem_to_reg_out), 32'h1);
        chk("lb_rd", 32'(rd_out), 32'd7);
        chk("lb_res", alu_result_out, 32'h103);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("lb_after_req", 32'(dmem_req), 32'h0);
        chk("bubble_rw", 32'(reg_write_out), 32'h0);

        // 3: SH 0x102, ack in third REQ cycle
        @(negedge clk);
        drive(1'b1, 32'h102, 32'h0000_ABCD, 3'b001, 5'd9, 1'b0, 1'b0, 1'b1);
        #1;
        chk("sh_stall0", 32'(mem_stall), 32'h1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            dmem_ack = (i == 2);
            #1;
            chk("sh_req", 32'(dmem_req), 32'h1);
            chk("sh_we", 32'(dmem_we), 32'h1);
            chk("sh_be", 32'(dmem_be), 32'hC);
            chk("sh_wdata", dmem_wdata, 32'hABCD_ABCD);
            chk("sh_addr", dmem_addr, 32'h100);
            chk("sh_rw", 32'(reg_write_out), 32'h0);
            chk("sh_stall", 32'(mem_stall), (i == 2) ? 32'h0 : 32'h1);
        end
        chk("sh_m2r", 32'(mem_to_reg_out), 32'h0);
        @(negedge clk);
        idle_inputs();

        // SB 0x101: single-lane enable, replicated byte
        @(negedge clk);
        drive(1'b1, 32'h101, 32'h1234_565A, 3'b000, 5'd1, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        dmem_ack = 1'b1;
        #1;
        chk("sb_be", 32'(dmem_be), 32'h2);
        chk("sb_wdata", dmem_wdata, 32'h5A5A_5A5A);
        @(negedge clk);
        idle_inputs();

        // 4: LW 0x101 misaligned
        @(negedge clk);
        drive(1'b1, 32'h101, 32'h0, 3'b010, 5'd4, 1'b1, 1'b1, 1'b0);
        #1;
        chk("lw_mis", 32'(misalign_fault), 32'h1);
        chk("lw_req", 32'(dmem_req), 32'h0);
        chk("lw_rw", 32'(reg_write_out), 32'h0);
        chk("lw_stall", 32'(mem_stall), 32'h0);
        @(negedge clk);
        idle_inputs();
        #1;
        chk("lw_req_after", 32'(dmem_req), 32'h0);
        chk("lw_mis_after", 32'(misalign_fault), 32'h0);

        // store with load-only funct3 is illegal
        @(negedge clk);
        drive(1'b1, 32'h200, 32'h0, 3'b100, 5'd0, 1'b0, 1'b0, 1'b1);
        #1;
        chk("sbu_mis", 32'(misalign_fault), 32'h1);
        @(negedge clk);
        idle_inputs();

        // 5: LHU 0x200, never acked
        @(negedge clk);
        drive(1'b1, 32'h200, 32'h0, 3'b101, 5'd6, 1'b1, 1'b1, 1'b0);
        n_req = 0;
        seen  = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            #1;
            if (dmem_req) n_req++;
            if (bus_fault) begin
                seen = 1'b1;
                chk("to_stall", 32'(mem_stall), 32'h0);
                chk("to_rw", 32'(reg_write_out), 32'h0);
            end
        end
        chk("to_seen", 32'(seen), 32'h1);
        chk("to_cycles", n_req, 32'd255);
        @(negedge clk);
        idle_inputs();
        dmem_ack = 1'b1;
        #1;
        chk("to_req_after", 32'(dmem_req), 32'h0);
        chk("late_ack_bf", 32'(bus_fault), 32'h0);
        chk("late_ack_rw", 32'(reg_write_out), 32'h0);
        @(negedge clk);
        idle_inputs();

        // 6: reset while in REQ, then LBU 0x0
        @(negedge clk);
        drive(1'b1, 32'h40, 32'h0, 3'b010, 5'd2, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        #1;
        chk("rr_req", 32'(dmem_req), 32'h1);
        #1;
        reset = 1'b1;
        #1;
        chk("rr_async", 32'(dmem_req), 32'h0);
        @(negedge clk);
        idle_inputs();
        reset = 1'b0;
        @(negedge clk);
        drive(1'b1, 32'h0, 32'h0, 3'b100, 5'd3, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h0000_0080;
        #1;
        chk("lbu_data", mem_r_data_out, 32'h0000_0080);
        chk("lbu_rw", 32'(reg_write_out), 32'h1);
        chk("lbu_rd", 32'(rd_out), 32'd3);
        @(negedge clk);
        idle_inputs();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
